arb_req_queue: RTL and testbench
================================

// Module: arb_req_queue
// PURPOSE
//  Request-side front end for priority_arbiter: buffers commands per requester channel in small FIFOs.
//  Drives req[] to the arbiter (req[i]=1 while channel i holds data) and consumes grnt[].
//  On a grant it pops the granted channel's head entry into a single registered output slot
//  with valid/ready handshake toward the shared resource.
// PARAMETERS
//  NUM_REQ  4  number of requester channels; matches the arbiter req/grnt width
//  DATA_W   8  command payload width
//  DEPTH    4  entries per channel FIFO; power of 2, >=2
// PORTS
//  clk        in   1             single clock, rising edge
//  rst        in   1             asynchronous, active-low reset
//  in_valid   in   1             upstream command valid
//  in_id      in   $clog2(NUM_REQ)  target channel of the command
//  in_data    in   DATA_W        command payload
//  in_ready   out  1             = count[in_id] < DEPTH (combinational from registered count)
//  req        out  NUM_REQ       to arbiter; req[i] = (count[i] != 0)
//  grnt       in   NUM_REQ       from arbiter; expected one-hot or zero
//  out_valid  out  1             output slot holds a command
//  out_id     out  $clog2(NUM_REQ)  channel the output command came from
//  out_data   out  DATA_W        output payload
//  out_ready  in   1             downstream accepts when out_valid & out_ready
// BEHAVIOUR
//  Reset (rst=0, async): all counts/pointers 0; req=0; out_valid=0; out_id=0; out_data=0; in_ready=1.
//  Push: in_valid & in_ready at posedge writes in_data to FIFO[in_id] tail; count+1. No bypass to output.
//  Full channel: in_ready=0 even if the same channel pops this cycle (no same-cycle push-on-full).
//  Output slot FSM, two states:
//   EMPTY: out_valid=0. Pop enabled -> FULL.
//   FULL : out_valid=1. out_ready=1 with pop -> FULL (reload); out_ready=1 without pop -> EMPTY;
//          out_ready=0 -> hold; out_id/out_data stable.
//  Pop enable: slot_free = (state==EMPTY) | out_ready. pop[i] = grnt[i] & (count[i]!=0) & slot_free.
//  Pop loads head of FIFO[i] into out_data, i into out_id; count[i]-1. Latency: grnt seen at edge N
//   -> out_valid at edge N+1 (one cycle).
//  Multi-hot grnt: only lowest set index popped; rest ignored.
//  Grant to empty channel: ignored, no state change.
//  Stall (slot not free): grant ignored, req[i] stays 1 so the arbiter re-grants.
//  Simultaneous push and pop same channel (not full): count unchanged, both pointers advance.
//  Pointers are $clog2(DEPTH) bits, wrap naturally; count is $clog2(DEPTH+1) bits, never over/underflows.
//  in_valid with in_id >= NUM_REQ: command dropped, in_ready=0.
//  Reset mid-operation: all queued and in-slot commands discarded immediately.
// CONFIGURATION
//  GRNT_ERR_EN defined: adds output grnt_err (1 bit, reset 0), sticky until reset; set on
//   grant to an empty channel or a multi-hot grnt.
//  GRNT_ERR_EN undefined: no grnt_err port; these conditions are silently ignored as above.
// STRUCTURE
//  Package arb_pkg: NUM_REQ, ID_W=$clog2(NUM_REQ), typedef of output-slot state enum
//   {SLOT_EMPTY, SLOT_FULL}, lowest-set-bit function for grant decode.
//  Sub-module arb_chan_fifo (DATA_W, DEPTH): one per channel, generate loop;
//   ports push/pop/din/dout/count. Top holds grant decode and output-slot FSM.
// TESTING
//  Reset: assert rst=0 mid-traffic -> req=0000, out_valid=0, in_ready=1 immediately.
//  Push ch1=0xA1, ch2=0xB2 -> req=0110; apply grnt=0010, out_ready=1 -> next edge out_valid=1,
//   out_id=1, out_data=0xA1, req=0100.
//  Fill ch3 with 4 entries -> in_ready=0 for in_id=3; 5th push not accepted; drain gives 4 entries in FIFO order.
//  out_ready=0 with out_valid=1, grnt=0100 -> no pop, out_data held, req[2] stays 1.
//  grnt=1111 with all channels non-empty -> only ch0 popped; with GRNT_ERR_EN grnt_err=1 next edge.
//  grnt=0001 with ch0 empty -> no change; with GRNT_ERR_EN grnt_err=1.
//  Same-cycle push/pop ch0 at count 2 -> count stays 2, order preserved.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter request queue: channel count, slot state, grant decode.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_e;

    // One-hot of the lowest set bit; all-zero input gives all-zero output.
    function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] r;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) r = NUM_REQ'(1) << i;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_chan_fifo.sv
// Per-channel command FIFO. The caller guarantees no push when full and no pop when empty.
module arb_chan_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PTR_W'(1);
            if (pop)  rd_q <= rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/arb_req_queue.sv
// Request-side front end for a priority arbiter: per-channel FIFOs feeding one registered output slot.
// Optional macro GRNT_ERR_EN adds a sticky grnt_err flag for grants to empty channels or multi-hot grants.
module arb_req_queue
    import arb_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [ID_W-1:0]    in_id,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] grnt,
    output logic               out_valid,
    output logic [ID_W-1:0]    out_id,
    output logic [DATA_W-1:0]  out_data,
`ifdef GRNT_ERR_EN
    output logic               grnt_err,
`endif
    input  logic               out_ready
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [NUM_REQ-1:0][CNT_W-1:0]  cnt;
    logic [NUM_REQ-1:0][DATA_W-1:0] head;
    logic [NUM_REQ-1:0]             push, pop, gsel;
    logic                           slot_free, pop_any;
    logic [ID_W-1:0]                pop_id;
    logic [DATA_W-1:0]              pop_data;

    slot_state_e       state_q, state_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    // Out-of-range ids match no channel, so in_ready stays low and the command is dropped.
    always_comb begin
        in_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (in_id == ID_W'(i)) in_ready = (cnt[i] < DEPTH_C);
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_chan
        assign req[g]  = (cnt[g] != '0);
        assign push[g] = in_valid & in_ready & (in_id == ID_W'(g));

        arb_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (in_data),
            .dout  (head[g]),
            .count (cnt[g])
        );
    end

    assign slot_free = (state_q == SLOT_EMPTY) | out_ready;
    assign gsel      = lowest_set(grnt);
    assign pop       = gsel & req & {NUM_REQ{slot_free}};
    assign pop_any   = |pop;

    always_comb begin
        pop_id   = '0;
        pop_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pop[i]) begin
                pop_id   = ID_W'(i);
                pop_data = head[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        out_id_d   = out_id_q;
        out_data_d = out_data_q;
        case (state_q)
            SLOT_EMPTY: if (pop_any) state_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !pop_any) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
        if (pop_any) begin
            out_id_d   = pop_id;
            out_data_d = pop_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SLOT_EMPTY;
            out_id_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            out_id_q   <= out_id_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;

`ifdef GRNT_ERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else if (|(grnt & ~req) || |(grnt & (grnt - NUM_REQ'(1)))) err_q <= 1'b1;
    end
    assign grnt_err = err_q;
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: behavioural channel model plus output scoreboard, table and directed sequences.
module tb_arb_req_queue;
    import arb_pkg::*;

    localparam int DW  = 8;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [1:0]    in_id;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [3:0]    req;
    logic [3:0]    grnt;
    logic          out_valid;
    logic [1:0]    out_id;
    logic [DW-1:0] out_data;
    logic          out_ready;
`ifdef GRNT_ERR_EN
    logic          grnt_err;
`endif

    always #5 clk = ~clk;

    arb_req_queue #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_id     (in_id),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .grnt      (grnt),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_data  (out_data),
`ifdef GRNT_ERR_EN
        .grnt_err  (grnt_err),
`endif
        .out_ready (out_ready)
    );

    typedef struct {
        logic       iv;
        logic [1:0] iid;
        logic [7:0] idata;
        logic [3:0] gr;
        logic       ordy;
        logic [3:0] exp_req;
    } vec_t;

    vec_t       tbl [9];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] mq [4][$];
    logic [9:0] exp_q [$];
    bit         m_vld;
    logic [1:0] m_id;
    logic [7:0] m_data;
    bit         m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        exp_q.delete();
        m_vld  = 0;
        m_id   = '0;
        m_data = '0;
        m_err  = 0;
    endtask

    // Immediate reset check, then release one edge later.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        in_valid = 0; in_id = '0; in_data = '0; grnt = '0; out_ready = 0;
        #1;
        chk({tag, "_req"}, req, 4'b0000);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_id"}, out_id, 2'd0);
        chk({tag, "_out_data"}, out_data, 8'h00);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
`ifdef GRNT_ERR_EN
        chk({tag, "_grnt_err"}, grnt_err, 1'b0);
`endif
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic cycle(input logic iv, input logic [1:0] iid, input logic [7:0] idata,
                         input logic [3:0] gr, input logic ordy);
        logic [3:0] ereq;
        bit         erdy, sfree, hs;
        int         idx;
        logic [9:0] e;
        in_valid = iv; in_id = iid; in_data = idata; grnt = gr; out_ready = ordy;
        #1;
        for (int i = 0; i < 4; i++) ereq[i] = (mq[i].size() != 0);
        erdy = (mq[iid].size() < DEP);
        chk("req", req, ereq);
        chk("in_ready", in_ready, erdy);
        sfree = !m_vld || ordy;
        hs    = m_vld && ordy;
        if (hs) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow: got output id %0h data %0h, required none", out_id, out_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_id", out_id, e[9:8]);
                chk("sb_data", out_data, e[7:0]);
            end
        end
        idx = -1;
        for (int i = 3; i >= 0; i--) if (gr[i]) idx = i;
        if ((gr & ~ereq) != 0) m_err = 1;
        if ((gr & (gr - 4'd1)) != 0) m_err = 1;
        if (idx >= 0 && ereq[idx] && sfree) begin
            m_data = mq[idx].pop_front();
            m_id   = idx[1:0];
            m_vld  = 1;
            exp_q.push_back({m_id, m_data});
        end else if (hs) begin
            m_vld = 0;
        end
        if (iv && erdy) mq[iid].push_back(idata);
        @(posedge clk); #1;
        chk("out_valid", out_valid, m_vld);
        if (m_vld) begin
            chk("out_id", out_id, m_id);
            chk("out_data", out_data, m_data);
        end
`ifdef GRNT_ERR_EN
        chk("grnt_err", grnt_err, m_err);
`endif
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'd1, 8'hA1, 4'b0000, 1'b1, 4'b0010};
        tbl[1] = '{1'b1, 2'd2, 8'hB2, 4'b0000, 1'b1, 4'b0110};
        tbl[2] = '{1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, 4'b0100};
        tbl[3] = '{1'b1, 2'd0, 8'hC0, 4'b0000, 1'b0, 4'b0101};
        tbl[4] = '{1'b0, 2'd0, 8'h00, 4'b0100, 1'b0, 4'b0101};
        tbl[5] = '{1'b0, 2'd0, 8'h00, 4'b0100, 1'b1, 4'b0001};
        tbl[6] = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0000};
        tbl[7] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000};
        tbl[8] = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b0000};

        model_clear();
        #2;
        do_reset("rst0");

        for (int k = 0; k < 9; k++) begin
            cycle(tbl[k].iv, tbl[k].iid, tbl[k].idata, tbl[k].gr, tbl[k].ordy);
            chk($sformatf("tbl%0d_req", k), req, tbl[k].exp_req);
        end

        // Fill channel 3, attempt a fifth push, then drain in FIFO order.
        for (int k = 0; k < 5; k++) cycle(1'b1, 2'd3, 8'hD0 + 8'(k), 4'b0000, 1'b1);
        chk("full_req", req, 4'b1000);
        in_id = 2'd3; #1;
        chk("full_in_ready", in_ready, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 2'd0, 8'h00, 4'b1000, 1'b1);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);
        chk("drain_req", req, 4'b0000);

        // Push and pop channel 0 in the same cycle at count 2; count must stay 2.
        cycle(1'b1, 2'd0, 8'h10, 4'b0000, 1'b1);
        cycle(1'b1, 2'd0, 8'h11, 4'b0000, 1'b1);
        cycle(1'b1, 2'd0, 8'h12, 4'b0001, 1'b1);
        cycle(1'b1, 2'd0, 8'h13, 4'b0000, 1'b1);
        cycle(1'b1, 2'd0, 8'h14, 4'b0000, 1'b1);
        cycle(1'b1, 2'd0, 8'h15, 4'b0000, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 2'd0, 8'h00, 4'b0001, 1'b1);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);

        // Reset in the middle of traffic with a full slot and queued entries.
        cycle(1'b1, 2'd1, 8'h31, 4'b0000, 1'b0);
        cycle(1'b1, 2'd2, 8'h32, 4'b0000, 1'b0);
        cycle(1'b1, 2'd2, 8'h33, 4'b0010, 1'b0);
        do_reset("rst_mid");

        // Multi-hot grant with every channel non-empty: only channel 0 pops.
        for (int k = 0; k < 4; k++) cycle(1'b1, 2'(k), 8'h20 + 8'(k), 4'b0000, 1'b1);
        cycle(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        chk("mh_req", req, 4'b1110);
        chk("mh_out_id", out_id, 2'd0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 2'd0, 8'h00, 4'b1110, 1'b1);
        cycle(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
